cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum cycles spent in FPU_WAIT before abort (1..255, 8-bit counter).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Cond  input  4  instruction condition field (ARM encoding).
REQ-005 SHALL have port ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-006 SHALL have port FPUFlags  input  2  {N,Z} from FPU, valid when fpu_done=1.
REQ-007 SHALL have ports FlagW, FPUFlagW  input  2 each  flag-write enables from decoder (bit1 = N,Z; bit0 = C,V).
REQ-008 SHALL have ports PCS, RegW, MemW, ResSrc  input  1 each  decoder controls; ResSrc=1 marks an FPU instruction.
REQ-009 SHALL have port fpu_done  input  1  FPU result valid pulse.
REQ-010 SHALL have ports PCSrc, RegWrite, MemWrite  output  1 each  condition-gated controls.
REQ-011 SHALL have ports fpu_start  output  1  one-cycle FPU launch pulse; Stall  output  1  hold PC/instruction.
REQ-012 SHALL have ports Flags  output  4  registered {N,Z,C,V}; fpu_err  output  1  sticky timeout flag.

Function
REQ-013 SHALL compute CondEx combinationally from registered Flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-014 SHALL implement FSM states IDLE and FPU_WAIT.
REQ-015 In IDLE with ResSrc=0: PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, Stall=0, fpu_start=0; zero added latency.
REQ-016 In IDLE with ResSrc=0 and CondEx=1: next edge SHALL load Flags[3:2] from ALUFlags[3:2] if FlagW[1], Flags[1:0] from ALUFlags[1:0] if FlagW[0].
REQ-017 In IDLE with ResSrc=1 and CondEx=0: instruction is a NOP; all write/branch outputs 0, Stall=0, no fpu_start, no flag update.
REQ-018 In IDLE with ResSrc=1 and CondEx=1: fpu_start=1 and Stall=1 this cycle, RegWrite/MemWrite/PCSrc=0, counter cleared, next state FPU_WAIT.
REQ-019 In FPU_WAIT without fpu_done: Stall=1, fpu_start=0, RegWrite/MemWrite/PCSrc=0, counter increments by 1 per cycle.
REQ-020 In FPU_WAIT with fpu_done=1 (commit cycle): RegWrite=RegW, MemWrite=0, PCSrc=PCS, Stall=0; Flags[3:2] loaded from FPUFlags if FPUFlagW[1]; Flags[1:0] unchanged; next state IDLE.
REQ-021 FPUFlagW[0] SHALL be ignored.
REQ-022 fpu_done SHALL be ignored in IDLE, including the fpu_start cycle.
REQ-023 In FPU_WAIT, counter==TIMEOUT with fpu_done=0 SHALL abort: fpu_err set to 1, RegWrite/PCSrc/MemWrite=0, Flags unchanged, Stall=0, next state IDLE.
REQ-024 If fpu_done=1 and counter==TIMEOUT coincide, commit (REQ-020) SHALL take priority and fpu_err SHALL not be set.
REQ-025 Counter SHALL saturate at TIMEOUT and never wrap.
REQ-026 fpu_err SHALL remain 1 until reset.
REQ-027 Decoder inputs are held constant by upstream while Stall=1; block SHALL reuse them at commit without internal capture.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, Flags=0000, counter=0, fpu_err=0, fpu_start=0, Stall=0.
REQ-029 Reset asserted in FPU_WAIT SHALL abandon the FPU operation with no RegWrite and no flag update, including when fpu_done arrives in the same cycle.
REQ-030 First edge after reset release SHALL evaluate CondEx against Flags=0000 (EQ fails, NE passes).

Verification
REQ-031 Flags=0000, Cond=1110, ResSrc=0, RegW=1, FlagW=11, ALUFlags=0100 -> RegWrite=1 same cycle; Flags=0100 next cycle.
REQ-032 Flags=0100, Cond=0001 (NE), RegW=1, MemW=1, PCS=1 -> RegWrite=MemWrite=PCSrc=0; Flags unchanged.
REQ-033 Cond=1110, ResSrc=1, RegW=1, FPUFlagW=10, fpu_done after 3 WAIT cycles with FPUFlags=10 -> fpu_start one cycle, Stall=1 for 4 cycles, RegWrite=1 on commit, Flags=10xx with C,V unchanged.
REQ-034 TIMEOUT=4, FPU instruction, no fpu_done -> abort on the 5th WAIT cycle: fpu_err=1, RegWrite=0, Stall=0, state IDLE; a second FPU instruction still launches.
REQ-035 fpu_done and counter==TIMEOUT in the same cycle -> commit, fpu_err=0.
REQ-036 reset=0 asserted in the 2nd FPU_WAIT cycle -> Stall=0 and Flags=0000 immediately; no RegWrite after release.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: ARM condition evaluation, flag register and FPU stall/commit/timeout control.
module cond_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FPUFlags,
    input  logic [1:0] FlagW,
    input  logic [1:0] FPUFlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       ResSrc,
    input  logic       fpu_done,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       fpu_start,
    output logic       Stall,
    output logic [3:0] Flags,
    output logic       fpu_err
);
    typedef enum logic {IDLE, FPU_WAIT} state_t;
    localparam logic [7:0] TMAX = 8'(TIMEOUT);
    state_t state;
    logic [7:0] cnt;
    logic cond_ex, n, z, c, v, wait_st, commit, abort, issue, alu;
    assign {n, z, c, v} = Flags;
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c & !z;
            4'b1001: cond_ex = !c | z;
            4'b1010: cond_ex = n == v;
            4'b1011: cond_ex = n != v;
            4'b1100: cond_ex = !z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    assign wait_st = state == FPU_WAIT;
    assign commit  = wait_st & fpu_done;
    assign abort   = wait_st & !fpu_done & (cnt == TMAX);
    assign issue   = !wait_st & ResSrc & cond_ex;
    assign alu     = !wait_st & !ResSrc & cond_ex;
    // outputs are gated by reset so an asserted reset kills any in-flight commit immediately
    assign PCSrc     = reset & (alu | commit) & PCS;
    assign RegWrite  = reset & (alu | commit) & RegW;
    assign MemWrite  = reset & alu & MemW;
    assign fpu_start = reset & issue;
    assign Stall     = reset & (issue | (wait_st & !fpu_done & !abort));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            Flags   <= 4'b0000;
            cnt     <= 8'd0;
            fpu_err <= 1'b0;
        end else begin
            if (alu && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (alu && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
            if (commit && FPUFlagW[1]) Flags[3:2] <= FPUFlags;
            if (abort) fpu_err <= 1'b1;
            if (issue) cnt <= 8'd0;
            else if (wait_st) cnt <= (cnt == TMAX) ? cnt : cnt + 8'd1;
            state <= issue ? FPU_WAIT : (commit || abort) ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random checks of cond_unit against a behavioural model.
module tb_cond_unit;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FPUFlags, FlagW, FPUFlagW;
    logic PCS, RegW, MemW, ResSrc, fpu_done;
    logic PCSrc, RegWrite, MemWrite, fpu_start, Stall, fpu_err;
    logic [3:0] Flags;
    int checks = 0;
    int errors = 0;
    bit [3:0] mf;
    bit merr, busy;
    int waited;

    cond_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FPUFlags(FPUFlags),
        .FlagW(FlagW), .FPUFlagW(FPUFlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .ResSrc(ResSrc), .fpu_done(fpu_done), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .fpu_start(fpu_start), .Stall(Stall), .Flags(Flags), .fpu_err(fpu_err)
    );

    always #5 clk = ~clk;

    // predicate picked by Cond[3:1], Cond[0] inverts it; 111x is always/never
    function automatic bit cond_ok(logic [3:0] cc, bit [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        bit r;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: return cc[0] == 1'b0;
        endcase
        return cc[0] ? !r : r;
    endfunction

    task automatic step(input string tag);
        bit pc, rw, mw, st, sl, ok, nbusy, nerr;
        bit [3:0] nf;
        int nw;
        pc = 0; rw = 0; mw = 0; st = 0; sl = 0;
        if (!reset) begin
            mf = 0; merr = 0; busy = 0; waited = 0;
        end
        nf = mf; nerr = merr; nbusy = busy; nw = waited;
        if (reset) begin
            if (!busy) begin
                ok = cond_ok(Cond, mf);
                if (ResSrc && ok) begin
                    st = 1; sl = 1; nbusy = 1; nw = 0;
                end else if (!ResSrc && ok) begin
                    pc = PCS; rw = RegW; mw = MemW;
                    if (FlagW[1]) nf[3:2] = ALUFlags[3:2];
                    if (FlagW[0]) nf[1:0] = ALUFlags[1:0];
                end
            end else if (fpu_done) begin
                pc = PCS; rw = RegW; nbusy = 0;
                if (FPUFlagW[1]) nf[3:2] = FPUFlags;
            end else if (waited == TO) begin
                nerr = 1; nbusy = 0;
            end else begin
                sl = 1; nw = waited + 1;
            end
        end
        #4;
        checks++;
        assert ({PCSrc, RegWrite, MemWrite, fpu_start, Stall} === {pc, rw, mw, st, sl})
        else begin
            errors++;
            $error("FAIL %s ctrl {PCSrc,RegWrite,MemWrite,fpu_start,Stall} got %b want %b", tag,
                   {PCSrc, RegWrite, MemWrite, fpu_start, Stall}, {pc, rw, mw, st, sl});
        end
        checks++;
        assert ({fpu_err, Flags} === {merr, mf})
        else begin
            errors++;
            $error("FAIL %s state {fpu_err,Flags} got %b want %b", tag, {fpu_err, Flags}, {merr, mf});
        end
        @(posedge clk);
        mf = nf; merr = nerr; busy = nbusy; waited = nw;
        #1;
    endtask

    task automatic alu_op(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw, input logic r, input logic m, input logic p);
        Cond = c; ALUFlags = af; FlagW = fw; RegW = r; MemW = m; PCS = p; ResSrc = 0; fpu_done = 0;
    endtask

    initial begin
        reset = 0; Cond = 0; ALUFlags = 0; FPUFlags = 0; FlagW = 0; FPUFlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; ResSrc = 0; fpu_done = 0;
        Cond = 4'b1110; ResSrc = 1; RegW = 1;
        step("reset_hold");
        step("reset_hold2");
        reset = 1;
        alu_op(4'b0000, 4'b1111, 2'b11, 1, 1, 1);
        step("eq_after_reset");
        alu_op(4'b0001, 4'b0000, 2'b00, 1, 0, 0);
        step("ne_after_reset");
        alu_op(4'b1110, 4'b0100, 2'b11, 1, 0, 0);
        step("al_write_flags");
        alu_op(4'b0001, 4'b1011, 2'b11, 1, 1, 1);
        step("ne_blocked");
        alu_op(4'b0000, 4'b0100, 2'b01, 0, 1, 1);
        step("eq_pass_cv_only");
        alu_op(4'b1110, 4'b0011, 2'b11, 0, 0, 0);
        step("set_cv");
        // FPU op: done asserted in the launch cycle must be ignored
        Cond = 4'b1110; ResSrc = 1; RegW = 1; PCS = 0; MemW = 1; FPUFlagW = 2'b10; FPUFlags = 2'b10; fpu_done = 1;
        step("fpu_start");
        fpu_done = 0;
        for (int i = 0; i < 3; i++) step("fpu_wait");
        fpu_done = 1;
        step("fpu_commit");
        fpu_done = 0; ResSrc = 0; RegW = 0; MemW = 0; Cond = 4'b1111;
        step("after_commit");
        ResSrc = 1; RegW = 1; Cond = 4'b1110; FPUFlagW = 2'b11; FPUFlags = 2'b01;
        step("edge_start");
        for (int i = 0; i < TO; i++) step("edge_wait");
        fpu_done = 1;
        step("edge_commit");
        fpu_done = 0;
        step("timeout_start");
        for (int i = 0; i < TO; i++) step("timeout_wait");
        step("timeout_abort");
        step("relaunch");
        fpu_done = 1;
        step("relaunch_commit");
        fpu_done = 0; FPUFlagW = 2'b10; FPUFlags = 2'b11;
        step("rst_start");
        step("rst_wait1");
        reset = 0; fpu_done = 1;
        step("rst_in_wait");
        reset = 1; fpu_done = 0; ResSrc = 0; Cond = 4'b0000;
        step("rst_release");
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            Cond = 4'($urandom);
            ALUFlags = 4'($urandom);
            FPUFlags = 2'($urandom);
            FlagW = 2'($urandom);
            FPUFlagW = 2'($urandom);
            {PCS, RegW, MemW} = 3'($urandom);
            ResSrc = ($urandom_range(0, 2) == 0);
            fpu_done = ($urandom_range(0, 3) == 0);
            step("random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
